detect_nms: RTL and testbench
=============================

DETECT_NMS -- requirements
Module: detect_nms

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 45, image width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT, default 45, image height in pixels.
REQ-003 SHALL have parameter MAX_DET, default 16, stored detections per frame (range 1..256).
REQ-004 SHALL have parameter RADIUS, default 4, suppression radius in pixels on each axis.
REQ-005 SHALL derive W_X = $clog2(IMG_WIDTH), W_Y = $clog2(IMG_HEIGHT), W_CNT = $clog2(MAX_DET+1).
REQ-006 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have din_valid, din_ready  in/out  1 each  detection input handshake.
REQ-009 SHALL have din_data  input  W_Y+W_X  packed {y, x} detection position, x in LSBs.
REQ-010 SHALL have frame_end_valid, frame_end_ready  in/out  1 each  end-of-frame token handshake.
REQ-011 SHALL have dout_valid, dout_ready  out/in  1 each  output handshake.
REQ-012 SHALL have dout_data  output  W_Y+W_X  surviving detection, same packing as din_data.
REQ-013 SHALL have dout_eot  output  1  marks last surviving detection of frame.
REQ-014 SHALL have done  output  1  one-cycle pulse when the frame flush completes.
REQ-015 SHALL have done_count  output  W_CNT  stored detections in the frame just flushed, valid with done.
REQ-016 SHALL have overflow  output  1  set with done if any non-suppressed detection was dropped for lack of storage.

Function
REQ-017 SHALL implement states COLLECT, COMPARE, FLUSH, DONE.
REQ-018 In COLLECT: din_ready=1; frame_end_ready=!din_valid; din has priority when both are valid.
REQ-019 On din handshake: latch candidate; if count==0, store at index 0 next cycle and stay in COLLECT; otherwise enter COMPARE with idx=0.
REQ-020 In COMPARE: din_ready=0, frame_end_ready=0; compare one stored entry per cycle.
REQ-021 Match SHALL be |cand.x-entry.x|<=RADIUS and |cand.y-entry.y|<=RADIUS, using unsigned absolute difference at W_X/W_Y width without wrap.
REQ-022 On a match: drop the candidate and return to COLLECT next cycle.
REQ-023 If idx==count-1 with no match: store at index count and increment count when count<MAX_DET, else set the sticky overflow flag; return to COLLECT.
REQ-024 Worst-case acceptance interval SHALL be count+1 cycles.
REQ-025 On frame_end handshake: go to FLUSH when count>0, else DONE.
REQ-026 In FLUSH: present entries 0..count-1 in storage order; dout_data SHALL be stable while dout_valid && !dout_ready; dout_eot=1 only on entry count-1.
REQ-027 After the dout_eot handshake, go to DONE.
REQ-028 In DONE, for one cycle: done=1, done_count=count, overflow=sticky flag; then clear count and flag and return to COLLECT.
REQ-029 done_count and overflow SHALL be 0 when done=0.

Reset
REQ-030 On rst: state=COLLECT, count=0, sticky flag=0, dout_valid=0, dout_eot=0, done=0, done_count=0, overflow=0.
REQ-031 On rst: din_ready=1, frame_end_ready=1.
REQ-032 Reset mid-COMPARE or mid-FLUSH SHALL discard all stored detections; no partial output resumes.

Structure
REQ-033 W_X/W_Y derivation and the state enum SHALL live in the shared cascade package, reused by window_pos.
REQ-034 Storage SHALL be a MAX_DET x (W_Y+W_X) register array, single module; no sub-module required.

Verification
REQ-035 Scenario: detections (10,10), (12,13), (30,30), then frame_end -> output (10,10), (30,30) with eot on second; done_count=2.
REQ-036 Scenario: boundary at RADIUS=4: (20,20) then (24,16) suppressed; (25,20) stored.
REQ-037 Scenario: frame_end with no detections -> no dout beat; done pulse with done_count=0.
REQ-038 Scenario: MAX_DET+2 detections spaced 10 px apart -> MAX_DET outputs; overflow=1 with done.
REQ-039 Scenario: dout_ready toggled 1-0-0-1 during FLUSH -> data held; no beat lost or duplicated.
REQ-040 Scenario: rst asserted mid-FLUSH -> dout_valid=0 next cycle; next frame starts with count=0.

Source files
------------

// File: rtl/detect_nms_pkg.sv
// rtl/detect_nms_pkg.sv - shared width helpers and detection FSM state type
package detect_nms_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_COMPARE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } nms_state_t;

    // Coordinate width for an axis of n pixels; never narrower than one bit.
    function automatic int pos_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/detect_nms.sv
// rtl/detect_nms.sv - per-frame non-maximum suppression of detection positions
module detect_nms
    import detect_nms_pkg::*;
#(
    parameter int IMG_WIDTH  = 45,
    parameter int IMG_HEIGHT = 45,
    parameter int MAX_DET    = 16,
    parameter int RADIUS     = 4,
    localparam int W_X       = pos_width(IMG_WIDTH),
    localparam int W_Y       = pos_width(IMG_HEIGHT),
    localparam int W_CNT     = $clog2(MAX_DET + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic [W_Y+W_X-1:0] din_data,
    input  logic               frame_end_valid,
    output logic               frame_end_ready,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [W_Y+W_X-1:0] dout_data,
    output logic               dout_eot,
    output logic               done,
    output logic [W_CNT-1:0]   done_count,
    output logic               overflow
);

    localparam int W_IDX              = pos_width(MAX_DET);
    localparam int W_D                = W_Y + W_X;
    localparam logic [31:0] RAD       = 32'(RADIUS);
    localparam logic [W_CNT-1:0] CMAX = W_CNT'(MAX_DET);

    nms_state_t       r_state;
    logic [W_D-1:0]   r_mem [MAX_DET];
    logic [W_D-1:0]   r_cand;
    logic [W_IDX-1:0] r_idx;
    logic [W_CNT-1:0] r_count;
    logic             r_ovf;
    logic             r_dout_valid;
    logic             r_dout_eot;
    logic             r_done;
    logic [W_CNT-1:0] r_done_count;
    logic             r_overflow;

    logic [W_D-1:0]   w_entry;
    logic [W_X-1:0]   w_cx, w_ex, w_dx;
    logic [W_Y-1:0]   w_cy, w_ey, w_dy;
    logic             w_match;
    logic [W_CNT-1:0] w_cnt_m1;
    logic             w_last;
    logic             w_wr_en;
    logic [W_IDX-1:0] w_wr_addr;
    logic [W_D-1:0]   w_wr_data;

    assign w_entry  = r_mem[r_idx];
    assign w_cx     = r_cand[W_X-1:0];
    assign w_cy     = r_cand[W_D-1:W_X];
    assign w_ex     = w_entry[W_X-1:0];
    assign w_ey     = w_entry[W_D-1:W_X];
    // Subtract smaller from larger so the distance never wraps.
    assign w_dx     = (w_cx >= w_ex) ? (w_cx - w_ex) : (w_ex - w_cx);
    assign w_dy     = (w_cy >= w_ey) ? (w_cy - w_ey) : (w_ey - w_cy);
    assign w_match  = (32'(w_dx) <= RAD) && (32'(w_dy) <= RAD);
    assign w_cnt_m1 = r_count - 1'b1;
    assign w_last   = (W_CNT'(r_idx) == w_cnt_m1);

    assign w_wr_en   = !rst && (((r_state == ST_COLLECT) && din_valid && (r_count == '0)) ||
                                ((r_state == ST_COMPARE) && !w_match && w_last && (r_count < CMAX)));
    assign w_wr_addr = (r_state == ST_COLLECT) ? '0 : r_count[W_IDX-1:0];
    assign w_wr_data = (r_state == ST_COLLECT) ? din_data : r_cand;

    assign din_ready       = (r_state == ST_COLLECT);
    assign frame_end_ready = (r_state == ST_COLLECT) && !din_valid;
    assign dout_valid      = r_dout_valid;
    assign dout_data       = w_entry;
    assign dout_eot        = r_dout_eot;
    assign done            = r_done;
    assign done_count      = r_done_count;
    assign overflow        = r_overflow;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_COLLECT;
            r_cand       <= '0;
            r_idx        <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_eot   <= 1'b0;
            r_done       <= 1'b0;
            r_done_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_done_count <= '0;
            r_overflow   <= 1'b0;
            case (r_state)
                ST_COLLECT: begin
                    if (din_valid) begin
                        r_cand <= din_data;
                        r_idx  <= '0;
                        if (r_count == '0) begin
                            r_count <= W_CNT'(1);
                        end else begin
                            r_state <= ST_COMPARE;
                        end
                    end else if (frame_end_valid) begin
                        r_idx <= '0;
                        if (r_count != '0) begin
                            r_state      <= ST_FLUSH;
                            r_dout_valid <= 1'b1;
                            r_dout_eot   <= (r_count == W_CNT'(1));
                        end else begin
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_done_count <= r_count;
                            r_overflow   <= r_ovf;
                        end
                    end
                end
                ST_COMPARE: begin
                    if (w_match) begin
                        r_state <= ST_COLLECT;
                    end else if (w_last) begin
                        if (r_count < CMAX) begin
                            r_count <= r_count + 1'b1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                        r_state <= ST_COLLECT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (dout_ready) begin
                        if (r_dout_eot) begin
                            r_dout_valid <= 1'b0;
                            r_dout_eot   <= 1'b0;
                            r_state      <= ST_DONE;
                            r_done       <= 1'b1;
                            r_done_count <= r_count;
                            r_overflow   <= r_ovf;
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_dout_eot <= ((W_CNT'(r_idx) + W_CNT'(1)) == w_cnt_m1);
                        end
                    end
                end
                ST_DONE: begin
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                    r_state <= ST_COLLECT;
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_detect_nms.sv
// tb/tb_detect_nms.sv - scoreboard bench for detect_nms against a list-based suppression model
module tb_detect_nms;

    localparam int IMG_W = 45;
    localparam int IMG_H = 45;
    localparam int MAXD  = 16;
    localparam int RAD   = 4;
    localparam int WX    = 6;
    localparam int WY    = 6;
    localparam int WC    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [WY+WX-1:0] din_data = '0;
    logic          frame_end_valid = 1'b0;
    logic          frame_end_ready;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic [WY+WX-1:0] dout_data;
    logic          dout_eot;
    logic          done;
    logic [WC-1:0] done_count;
    logic          overflow;

    always #5 clk = ~clk;

    detect_nms #(
        .IMG_WIDTH (IMG_W),
        .IMG_HEIGHT(IMG_H),
        .MAX_DET   (MAXD),
        .RADIUS    (RAD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .din_data       (din_data),
        .frame_end_valid(frame_end_valid),
        .frame_end_ready(frame_end_ready),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .dout_data      (dout_data),
        .dout_eot       (dout_eot),
        .done           (done),
        .done_count     (done_count),
        .overflow       (overflow)
    );

    typedef struct {int x; int y; bit eot;} beat_t;
    typedef struct {int cnt; bit ovf;} done_t;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    done_t done_q[$];
    int    model_x[$];
    int    model_y[$];
    bit    model_ovf = 1'b0;
    int    n_beats = 0;
    int    rdy_mode = 0;
    int    rdy_cyc = 0;

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: a candidate survives only if no kept detection lies within RAD on both axes.
    function automatic void model_apply(input int x, input int y);
        foreach (model_x[i]) begin
            if (iabs(x - model_x[i]) <= RAD && iabs(y - model_y[i]) <= RAD) return;
        end
        if (model_x.size() < MAXD) begin
            model_x.push_back(x);
            model_y.push_back(y);
        end else begin
            model_ovf = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        #1;
        rdy_cyc++;
        if (rdy_mode == 1) dout_ready = ((rdy_cyc % 4) == 0) || ((rdy_cyc % 4) == 3);
        else               dout_ready = ($urandom_range(0, 3) != 0);
    end

    logic [WY+WX-1:0] prev_data;
    bit               prev_stall = 1'b0;

    always @(negedge clk) begin
        beat_t b;
        done_t d;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", int'(dout_valid), 1);
                check("hold_data", int'(dout_data), int'(prev_data));
            end
            if (dout_valid && dout_ready) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("dout_x", int'(dout_data[WX-1:0]), b.x);
                    check("dout_y", int'(dout_data[WY+WX-1:WX]), b.y);
                    check("dout_eot", int'(dout_eot), int'(b.eot));
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    d = done_q.pop_front();
                    check("done_count", int'(done_count), d.cnt);
                    check("overflow", int'(overflow), int'(d.ovf));
                end
            end else begin
                check("idle_done_count", int'(done_count), 0);
                check("idle_overflow", int'(overflow), 0);
            end
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_det(input int x, input int y);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        din_valid = 1'b1;
        din_data  = {WY'(y), WX'(x)};
        while (!ok) begin
            @(negedge clk);
            if (din_ready) ok = 1'b1;
            else begin
                t++;
                if (t > 200) begin
                    check("din_timeout", 0, 1);
                    break;
                end
            end
        end
        if (ok) model_apply(x, y);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic send_frame_end(input bit wait_done);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b0;
        frame_end_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            if (frame_end_ready) ok = 1'b1;
            else begin
                t++;
                if (t > 200) begin
                    check("frame_end_timeout", 0, 1);
                    break;
                end
            end
        end
        if (ok) begin
            foreach (model_x[i])
                exp_q.push_back('{x: model_x[i], y: model_y[i], eot: (i == model_x.size() - 1)});
            done_q.push_back('{cnt: model_x.size(), ovf: model_ovf});
        end
        model_x.delete();
        model_y.delete();
        model_ovf = 1'b0;
        @(posedge clk);
        #1;
        frame_end_valid = 1'b0;
        if (wait_done) begin
            t = 0;
            while (done_q.size() != 0) begin
                @(negedge clk);
                t++;
                if (t > 3000) begin
                    check("done_timeout", 0, 1);
                    done_q.delete();
                    exp_q.delete();
                end
            end
            tick();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        repeat (3) tick();
        @(negedge clk);
        check("rst_din_ready", int'(din_ready), 1);
        check("rst_frame_end_ready", int'(frame_end_ready), 1);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_dout_eot", int'(dout_eot), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_count", int'(done_count), 0);
        check("rst_overflow", int'(overflow), 0);
        tick();
        rst = 1'b0;
        tick();

        send_det(10, 10);
        send_det(12, 13);
        send_det(30, 30);
        send_frame_end(1'b1);

        send_det(20, 20);
        send_det(24, 16);
        send_det(25, 20);
        send_frame_end(1'b1);

        send_frame_end(1'b1);

        for (int i = 0; i < MAXD + 2; i++) send_det((i % 4) * 10, (i / 4) * 10);
        send_frame_end(1'b1);

        rdy_mode = 1;
        for (int i = 0; i < 6; i++) send_det(i * 7, 40 - i * 7);
        send_frame_end(1'b1);

        for (int i = 0; i < 5; i++) send_det(5 + i * 9, 5);
        send_frame_end(1'b0);
        base = n_beats;
        t = 0;
        while (n_beats < base + 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("flush_progress", int'(n_beats >= base + 2), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_dout_valid", int'(dout_valid), 0);
        check("post_rst_din_ready", int'(din_ready), 1);
        check("post_rst_done", int'(done), 0);
        tick();
        send_det(10, 10);
        send_frame_end(1'b1);
        rdy_mode = 0;

        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(0, 22);
            for (int k = 0; k < n; k++) begin
                send_det($urandom_range(0, IMG_W - 1), $urandom_range(0, IMG_H - 1));
                repeat ($urandom_range(0, 2)) tick();
            end
            send_frame_end(1'b1);
        end

        repeat (5) tick();
        check("exp_q_drained", exp_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
